// File: rtl/sodor5_instr_sequencer_pkg.sv
// sodor5_seq_pkg: shared states, opcodes and the LFSR-to-instruction mapping
package sodor5_seq_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [6:0]  OP_IMM  = 7'b0010011;
    localparam logic [6:0]  OP_LOAD = 7'b0000011;

    // Shift immediates keep only a legal shamt (plus the SRAI bit); loads are limited to LB/LBU
    function automatic logic [31:0] gen_instr(input logic [31:0] r, input logic [11:0] load_mask);
        logic [2:0]  f3;
        logic [11:0] imm;
        f3  = r[31] ? r[19:17] : {r[19], 2'b00};
        imm = !r[31]      ? r[11:0] & load_mask :
              f3 == 3'd5  ? r[11:0] & 12'h41F :
              f3 == 3'd1  ? r[11:0] & 12'h01F : r[11:0];
        return {imm, r[16:12], f3, r[24:20], r[31] ? OP_IMM : OP_LOAD};
    endfunction

endpackage

// File: rtl/sodor5_instr_sequencer_if.sv
// sodor5_instr_sequencer_if: control and instruction-stream signals of the sequencer
interface sodor5_instr_sequencer_if;
    logic        start;
    logic        stall;
    logic [31:0] instr;
    logic        instr_valid;
    logic [15:0] issue_count;
    logic        busy;
    logic        done;

    modport master (input start, stall, output instr, instr_valid, issue_count, busy, done);
    modport slave  (output start, stall, input instr, instr_valid, issue_count, busy, done);
endinterface

// File: rtl/sodor5_lfsr32.sv
// sodor5_lfsr32: 32-bit Fibonacci LFSR, taps 31/21/1/0, reseeded on reset
module sodor5_lfsr32 (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_seed,
    input  logic        i_en,
    output logic [31:0] o_value
);
    logic [31:0] r_lfsr;
    logic        w_fb;

    assign w_fb    = r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0];
    assign o_value = r_lfsr;

    // An all-zero state would lock up, so a zero seed becomes 1
    always_ff @(posedge clk) begin
        if (reset) r_lfsr <= (i_seed == 32'd0) ? 32'd1 : i_seed;
        else if (i_en) r_lfsr <= {r_lfsr[30:0], w_fb};
    end
endmodule

// File: rtl/sodor5_instr_sequencer.sv
// sodor5_instr_sequencer: issues NUM_INSTRS LFSR-generated RV32I words, then drains with NOPs
module sodor5_instr_sequencer
    import sodor5_seq_pkg::*;
#(
    parameter int unsigned NUM_INSTRS    = 100,
    parameter int unsigned DRAIN_CYCLES  = 5,
    parameter logic [31:0] SEED          = 32'h0000_0017,
    parameter logic [11:0] LOAD_IMM_MASK = 12'hFFF
) (
    input logic                       clk,
    input logic                       reset,
    sodor5_instr_sequencer_if.master  bus
);
    state_t      r_state, w_state;
    logic [31:0] r_instr, w_instr, w_lfsr;
    logic        r_valid, w_valid, w_adv, w_issue;
    logic [15:0] r_count, w_count;
    logic [7:0]  r_drain, w_drain;

    sodor5_lfsr32 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .i_seed  (SEED),
        .i_en    (w_adv),
        .o_value (w_lfsr)
    );

    assign w_issue = r_valid && !bus.stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_instr <= NOP;
            r_valid <= 1'b0;
            r_count <= 16'd0;
            r_drain <= 8'd0;
        end else begin
            r_state <= w_state;
            r_instr <= w_instr;
            r_valid <= w_valid;
            r_count <= w_count;
            r_drain <= w_drain;
        end
    end

    // The LFSR steps exactly when a generated word is loaded into instr
    always_comb begin
        w_state = r_state;
        w_instr = r_instr;
        w_valid = r_valid;
        w_count = r_count;
        w_drain = r_drain;
        w_adv   = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_instr = gen_instr(w_lfsr, LOAD_IMM_MASK);
                    w_adv   = 1'b1;
                    w_valid = 1'b1;
                    w_count = 16'd0;
                    w_state = ISSUE;
                end
            end
            ISSUE: begin
                if (w_issue) begin
                    w_count = r_count + 16'd1;
                    if (w_count == 16'(NUM_INSTRS)) begin
                        w_instr = NOP;
                        w_valid = 1'b0;
                        w_drain = 8'(DRAIN_CYCLES);
                        w_state = DRAIN;
                    end else begin
                        w_instr = gen_instr(w_lfsr, LOAD_IMM_MASK);
                        w_adv   = 1'b1;
                    end
                end
            end
            DRAIN: begin
                w_drain = r_drain - 8'd1;
                w_state = (r_drain == 8'd1) ? DONE : DRAIN;
            end
        endcase
    end

    assign bus.instr       = r_instr;
    assign bus.instr_valid = r_valid;
    assign bus.issue_count = r_count;
    assign bus.busy        = (r_state == ISSUE) || (r_state == DRAIN);
    assign bus.done        = (r_state == DONE);
endmodule

// File: tb/tb_sodor5_instr_sequencer.sv
// tb_sodor5_instr_sequencer: scoreboard bench against a run-level model of the sequencer
module tb_sodor5_instr_sequencer;
    localparam int          N      = 4;
    localparam int          D      = 3;
    localparam logic [31:0] SEED_A = 32'h0000_0017;
    localparam logic [31:0] SEED_B = 32'h800A_FFFF;
    localparam logic [11:0] LMASK  = 12'hFFF;
    localparam logic [31:0] NOPW   = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sodor5_instr_sequencer_if bus ();
    sodor5_instr_sequencer_if bus2 ();
    assign bus2.start = bus.start;
    assign bus2.stall = bus.stall;

    sodor5_instr_sequencer #(.NUM_INSTRS(N), .DRAIN_CYCLES(D), .SEED(SEED_A), .LOAD_IMM_MASK(LMASK))
        dut (.clk(clk), .reset(reset), .bus(bus));
    sodor5_instr_sequencer #(.NUM_INSTRS(N), .DRAIN_CYCLES(D), .SEED(SEED_B), .LOAD_IMM_MASK(LMASK))
        dut_b (.clk(clk), .reset(reset), .bus(bus2));

    int total = 0;
    int bad = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_lfsr = SEED_A;
    int          m_left = 0;
    int          m_drain = 0;
    int          m_issued = 0;
    bit          m_done = 1'b0;

    function automatic logic [31:0] ref_gen(input logic [31:0] r);
        int unsigned imm, f3;
        imm = r & 32'hFFF;
        if (r[31]) begin
            f3 = (r >> 17) & 7;
            if (f3 == 5) imm &= 32'h41F;
            else if (f3 == 1) imm &= 32'h1F;
        end else begin
            f3 = r[19] ? 4 : 0;
            imm &= 32'(LMASK);
        end
        return (imm << 20) | (((r >> 12) & 31) << 15) | (f3 << 12) | (((r >> 20) & 31) << 7)
               | (r[31] ? 32'h13 : 32'h03);
    endfunction

    function automatic logic [31:0] ref_next(input logic [31:0] r);
        return (r << 1) | 32'(r[31] ^ r[21] ^ r[1] ^ r[0]);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Run-level model: a run is N accepted words followed by D drain cycles
    task automatic model_edge();
        if (reset) begin
            m_left = 0; m_drain = 0; m_issued = 0; m_done = 1'b0;
            m_lfsr = SEED_A;
            exp_q.delete();
        end else if (m_left > 0) begin
            if (!bus.stall) begin
                m_issued++;
                m_left--;
                if (m_left == 0) m_drain = D;
            end
        end else if (m_drain > 0) begin
            m_drain--;
            if (m_drain == 0) m_done = 1'b1;
        end else if (bus.start) begin
            m_done = 1'b0; m_issued = 0; m_left = N;
            for (int i = 0; i < N; i++) begin
                exp_q.push_back(ref_gen(m_lfsr));
                m_lfsr = ref_next(m_lfsr);
            end
        end
    endtask

    task automatic cyc(input logic s, input logic st, input logic rs);
        bus.start = s;
        bus.stall = st;
        reset = rs;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run_to_done(input int n0, output int n, output int v);
        n = n0;
        v = int'(bus.instr_valid);
        while (!bus.done && n < 40) begin
            cyc(1'b0, 1'b0, 1'b0);
            n++;
            v += int'(bus.instr_valid);
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("valid", 32'(bus.instr_valid), 32'(m_left > 0));
            check("busy", 32'(bus.busy), 32'(m_left > 0 || m_drain > 0));
            check("done", 32'(bus.done), 32'(m_done));
            check("issue_count", 32'(bus.issue_count), 32'(m_issued));
            if (m_left > 0) begin
                if (exp_q.size() == 0) check("queue_empty", 32'd1, 32'd0);
                else begin
                    check("instr", bus.instr, exp_q[0]);
                    if (!bus.stall) void'(exp_q.pop_front());
                end
            end else check("nop", bus.instr, NOPW);
        end
    end

    initial begin
        int n, v;
        logic [31:0] held;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        check("reset_instr", bus.instr, NOPW);
        check("reset_flags", {28'd0, bus.instr_valid, bus.busy, bus.done, 1'b0}, 32'd0);
        check("reset_count", 32'(bus.issue_count), 32'd0);

        cyc(1'b1, 1'b0, 1'b0);
        check("first_instr", bus.instr, 32'h0170_0003);
        check("first_valid", 32'(bus.instr_valid), 32'd1);
        check("seed_b_instr", bus2.instr, 32'h41F7_D013);
        run_to_done(1, n, v);
        check("done_latency", 32'(n), 32'd8);
        check("valid_cycles", 32'(v), 32'd4);
        check("final_count", 32'(bus.issue_count), 32'd4);

        cyc(1'b1, 1'b0, 1'b0);
        check("done_clears", 32'(bus.done), 32'd0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        held = bus.instr;
        cyc(1'b0, 1'b1, 1'b0);
        check("stall_hold1", bus.instr, held);
        cyc(1'b0, 1'b1, 1'b0);
        check("stall_hold2", bus.instr, held);
        run_to_done(5, n, v);
        check("stall_latency", 32'(n), 32'd10);

        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("start_ignored", 32'(bus.issue_count), 32'd2);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        check("restart_instr", bus.instr, 32'h0170_0003);
        check("restart_count", 32'(bus.issue_count), 32'd0);
        run_to_done(1, n, v);
        check("restart_latency", 32'(n), 32'd8);

        for (int i = 0; i < 3000; i++)
            cyc(($urandom % 6) == 0, ($urandom % 4) == 0, ($urandom % 250) == 0);
        cyc(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sodor5_instr_sequencer.md
# sodor5_instr_sequencer

- Drives the instruction word into the sodor5 verification harness in place of a free-running testbench stimulus loop.
- Generates a seeded, reproducible stream of RV32I I-type ALU and load instructions from an LFSR, then drains the pipeline with NOPs.
- Supports a stall input that holds the current word, and flags completion so a checker can start its register-file and memory comparison.

## Interface
Parameters:
- NUM_INSTRS, 100: instructions issued per run; legal range 1..65535.
- DRAIN_CYCLES, 5: NOP cycles after the last issue; legal range 1..255.
- SEED, 32'h0000_0017: LFSR value at reset. A SEED of 0 is replaced by 1.
- LOAD_IMM_MASK, 12'hFFF: AND-mask applied to the load immediate.

Ports:
- clk, input, 1: sole clock, rising edge.
- reset, input, 1: synchronous, active-high.
- start, input, 1: begins a run; sampled only in IDLE and DONE.
- stall, input, 1: holds the current instr and the LFSR.
- instr, output, 32: instruction word, registered.
- instr_valid, output, 1: instr is a generated instruction, not padding.
- issue_count, output, 16: instructions accepted in the current run.
- busy, output, 1: high in ISSUE and DRAIN.
- done, output, 1: high in DONE.

## Operation
- Reset values: state IDLE, instr 32'h0000_0013 (NOP), instr_valid 0, issue_count 0, busy 0, done 0, lfsr SEED.
- LFSR: 32-bit Fibonacci, fb = l[31]^l[21]^l[1]^l[0], next = {l[30:0], fb}. It advances only when a word is loaded into instr.
- gen(r), when r[31]=1 (I-type ALU):
  - imm = r[11:0], rs1 = r[16:12], f3 = r[19:17], rd = r[24:20].
  - If f3==5, imm &= 12'h41F. If f3==1, imm &= 12'h01F.
  - instr = {imm, rs1, f3, rd, 7'b0010011}.
- gen(r), when r[31]=0 (load):
  - imm = r[11:0] & LOAD_IMM_MASK; f3 = {r[19], 2'b00}, i.e. LB or LBU.
  - instr = {imm, rs1, f3, rd, 7'b0000011}.
- An issue occurs on any cycle with instr_valid && !stall.
- IDLE:
  - Outputs: NOP, valid 0.
  - On start: instr <= gen(lfsr), advance lfsr, valid <= 1, issue_count <= 0, go to ISSUE.
- ISSUE:
  - On an issue: issue_count += 1.
  - If the new count == NUM_INSTRS: instr <= NOP, valid <= 0, load the drain counter with DRAIN_CYCLES, go to DRAIN.
  - Otherwise: instr <= gen(lfsr) and advance lfsr.
  - While stall=1: everything holds.
- DRAIN:
  - Outputs NOP and ignores stall.
  - The counter decrements each cycle; at 1 the block goes to DONE.
- DONE:
  - done=1, NOP out, issue_count holds.
  - On start: behaves as start in IDLE.
  - The LFSR is not reseeded, so a second run continues the sequence.
- start while busy is ignored.
- reset in any state returns to IDLE with reset values and reseeds the LFSR. A partially issued run is abandoned.

## Timing
- start sampled at edge t: the first instruction is on instr from cycle t+1, with instr_valid=1 and busy=1.
- Without stall, instruction k (0-based) appears in cycle t+1+k. valid falls in cycle t+1+NUM_INSTRS.
- done rises in cycle t+1+NUM_INSTRS+DRAIN_CYCLES.
- Each stalled cycle in ISSUE delays all later events by exactly one cycle.
- stall asserted on the final valid cycle delays the transition to DRAIN.
- issue_count updates the cycle after the issue edge.

## Structure
- A shared package sodor5_seq_pkg holds:
  - state enum {IDLE, ISSUE, DRAIN, DONE};
  - NOP constant 32'h0000_0013;
  - opcode constants OP_IMM 7'b0010011 and OP_LOAD 7'b0000011;
  - a gen_instr function.
- One sub-module, sodor5_lfsr32: seed, enable, value. It is reused by other traces.
- The FSM, counters and output register stay in the top module.

## Test plan
- Reset with SEED=32'h17, then pulse start: cycle 1 instr=32'h0170_0003 with valid=1, and the LFSR becomes 32'h2E.
- SEED=32'h800A_FFFF, start: first instr=32'h41F7_D013 (shift-imm masked to 12'h41F).
- NUM_INSTRS=4, DRAIN_CYCLES=3, no stall:
  - valid is high for exactly 4 cycles, then NOP for 3;
  - done rises 8 cycles after start, and issue_count=4.
- Same configuration with stall held for 2 cycles during instruction 2: instr is held unchanged, and done is delayed by 2 cycles to 10.
- reset asserted mid-ISSUE then start again: the instruction stream repeats from gen(SEED), and issue_count restarts at 0.
- start asserted during ISSUE: ignored, no count reset. start in DONE: new run continues the LFSR sequence and done clears the next cycle.
